dmem_access_ctrl: RTL and testbench

- MEM-stage sequencer for data-memory accesses.
- Accepts one load/store per instruction from the pipeline and runs a req/ack handshake with a variable-latency data memory.
- Generates byte enables and lane-steered store data.
- Stalls the pipeline while an access is outstanding.
- Hands the raw read word plus size/sign/low-address controls to the WB load extender.
- Flags misaligned accesses and memory timeouts.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_lane_steer.sv | 34 +++
 rtl/dmem_access_ctrl.sv | 134 +++++++++++++
 tb/tb_dmem_access_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access path.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_steer.sv
// Byte-enable / store-lane steering and alignment check for one access.
module dmem_lane_steer
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_out,
  output logic        misalign
);

  always_comb begin
    be        = 4'b1111;
    wdata_out = wdata;
    misalign  = 1'b0;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_out = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_out = {2{wdata[15:0]}};
        misalign  = addr_lo[0];
      end
      default: misalign = |addr_lo;  // word and the reserved encoding 11
    endcase
    // Loads always fetch the full word; the extender picks the lane later.
    if (!we) be = 4'b1111;
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer: req/ack handshake with data memory, pipeline stall,
// load-extender controls, misalign and timeout exceptions.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic        mem_sign,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        ld_is_byte,
  output logic        ld_is_half,
  output logic        ld_exsign,
  output logic [1:0]  ld_low_addr,
  output logic        misalign,
  output logic        bus_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  dmem_state_t      state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             pend_is_byte_reg;
  logic             pend_is_half_reg;
  logic             pend_exsign_reg;
  logic [1:0]       pend_low_addr_reg;

  logic [3:0]  steer_be;
  logic [31:0] steer_wdata;
  logic        steer_misalign;

  dmem_lane_steer u_steer (
    .size      (mem_size),
    .addr_lo   (mem_addr[1:0]),
    .we        (mem_we),
    .wdata     (mem_wdata),
    .be        (steer_be),
    .wdata_out (steer_wdata),
    .misalign  (steer_misalign)
  );

  // The issue cycle must already freeze the pipeline, so stall is combinational.
  assign stall = (state_reg == ST_ACCESS) ||
                 ((state_reg == ST_IDLE) && mem_valid && !steer_misalign);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg         <= ST_IDLE;
      cnt_reg           <= '0;
      pend_is_byte_reg  <= 1'b0;
      pend_is_half_reg  <= 1'b0;
      pend_exsign_reg   <= 1'b0;
      pend_low_addr_reg <= 2'b00;
      dm_req            <= 1'b0;
      dm_we             <= 1'b0;
      dm_addr           <= '0;
      dm_be             <= '0;
      dm_wdata          <= '0;
      ld_valid          <= 1'b0;
      ld_data           <= '0;
      ld_is_byte        <= 1'b0;
      ld_is_half        <= 1'b0;
      ld_exsign         <= 1'b0;
      ld_low_addr       <= 2'b00;
      misalign          <= 1'b0;
      bus_err           <= 1'b0;
    end else begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      ld_valid <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (mem_valid) begin
            if (steer_misalign) begin
              misalign <= 1'b1;
            end else begin
              dm_req            <= 1'b1;
              dm_we             <= mem_we;
              dm_addr           <= {mem_addr[31:2], 2'b00};
              dm_be             <= steer_be;
              dm_wdata          <= steer_wdata;
              pend_is_byte_reg  <= (mem_size == SZ_BYTE);
              pend_is_half_reg  <= (mem_size == SZ_HALF);
              pend_exsign_reg   <= mem_sign;
              pend_low_addr_reg <= mem_addr[1:0];
              cnt_reg           <= '0;
              state_reg         <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          // Ack is checked first so it wins over a simultaneous timeout.
          if (dm_ack) begin
            dm_req <= 1'b0;
            if (!dm_we) begin
              ld_valid    <= 1'b1;
              ld_data     <= dm_rdata;
              ld_is_byte  <= pend_is_byte_reg;
              ld_is_half  <= pend_is_half_reg;
              ld_exsign   <= pend_exsign_reg;
              ld_low_addr <= pend_low_addr_reg;
            end
            state_reg <= ST_DONE;
          end else if (cnt_reg == CNT_LAST) begin
            dm_req    <= 1'b0;
            bus_err   <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_DONE:  state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed and randomized checks of dmem_access_ctrl against an arithmetic reference model.
module tb_dmem_access_ctrl;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        mem_valid;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_is_byte;
  logic        ld_is_half;
  logic        ld_exsign;
  logic [1:0]  ld_low_addr;
  logic        misalign;
  logic        bus_err;

  int errors = 0;
  int checks = 0;

  // Reference copy of the load-extender fields (last completed load).
  logic [31:0] m_ld_data;
  logic        m_ld_byte;
  logic        m_ld_half;
  logic        m_ld_sign;
  logic [1:0]  m_ld_low;

  dmem_access_ctrl #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_size(mem_size), .mem_sign(mem_sign),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_is_byte(ld_is_byte), .ld_is_half(ld_is_half),
    .ld_exsign(ld_exsign), .ld_low_addr(ld_low_addr), .misalign(misalign), .bus_err(bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req_v);
    checks++;
    assert (obs === req_v)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req_v);
    end
  endtask

  function automatic bit m_misalign(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd0) return 1'b0;
    if (size == 2'd1) return (addr % 2) != 0;
    return (addr % 4) != 0;
  endfunction

  function automatic logic [31:0] m_be(input bit we, input logic [1:0] size, input logic [31:0] addr);
    if (!we) return 32'd15;
    if (size == 2'd0) return 32'd1 << (addr % 4);
    if (size == 2'd1) return ((addr % 4) >= 2) ? 32'd12 : 32'd3;
    return 32'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  task automatic chk_ld_hold(input string tag);
    chk({tag, "_ld_data"}, ld_data, m_ld_data);
    chk({tag, "_ld_byte"}, 32'(ld_is_byte), 32'(m_ld_byte));
    chk({tag, "_ld_half"}, 32'(ld_is_half), 32'(m_ld_half));
    chk({tag, "_ld_sign"}, 32'(ld_exsign), 32'(m_ld_sign));
    chk({tag, "_ld_low"}, 32'(ld_low_addr), 32'(m_ld_low));
  endtask

  // One pipeline memory op; entered and left at a negedge with the DUT idle.
  // lat = ACCESS cycle (1-based) on which ack is returned; lat > TO means none.
  task automatic do_op(input bit we, input logic [1:0] size, input bit sign,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int lat);
    bit mis;
    bit acked;
    int stalls;
    mis = m_misalign(size, addr);
    mem_valid = 1'b1; mem_we = we; mem_size = size; mem_sign = sign;
    mem_addr = addr; mem_wdata = wd; dm_ack = 1'b0;
    #1;
    chk("stall_issue", 32'(stall), 32'(!mis));
    stalls = 1;
    if (mis) begin
      @(negedge clk);
      chk("misalign_pulse", 32'(misalign), 32'd1);
      chk("misalign_noreq", 32'(dm_req), 32'd0);
      mem_valid = 1'b0;
      #1 chk("misalign_stall", 32'(stall), 32'd0);
      @(negedge clk);
      chk("misalign_end", 32'(misalign), 32'd0);
      chk("misalign_noreq2", 32'(dm_req), 32'd0);
      $display("op we=%0d size=%0d addr=%h -> misaligned", we, size, addr);
      return;
    end
    acked = 1'b0;
    for (int k = 1; k <= TO && !acked; k++) begin
      @(negedge clk);
      chk("req_high", 32'(dm_req), 32'd1);
      chk("acc_stall", 32'(stall), 32'd1);
      chk("dm_addr", dm_addr, addr & 32'hFFFF_FFFC);
      chk("dm_be", 32'(dm_be), m_be(we, size, addr));
      chk("dm_we", 32'(dm_we), 32'(we));
      if (we) chk("dm_wdata", dm_wdata, m_wdata(size, wd));
      chk("acc_no_buserr", 32'(bus_err), 32'd0);
      stalls++;
      if (k == lat) begin
        dm_ack = 1'b1;
        dm_rdata = rd;
        acked = 1'b1;
      end
    end
    @(negedge clk);
    dm_ack = 1'b0;
    dm_rdata = $urandom;
    if (acked) begin
      chk("done_stall", 32'(stall), 32'd0);
      chk("done_req", 32'(dm_req), 32'd0);
      chk("ld_valid", 32'(ld_valid), 32'(!we));
      if (!we) begin
        m_ld_data = rd;
        m_ld_byte = (size == 2'd0);
        m_ld_half = (size == 2'd1);
        m_ld_sign = sign;
        m_ld_low  = 2'(addr % 4);
      end
      chk_ld_hold("done");
      chk("stall_cycles", 32'(stalls), 32'(lat + 1));
      @(negedge clk);
      chk("no_double_issue", 32'(dm_req), 32'd0);
      chk("ld_valid_pulse", 32'(ld_valid), 32'd0);
      $display("op we=%0d size=%0d addr=%h lat=%0d -> done", we, size, addr, lat);
    end else begin
      chk("bus_err_pulse", 32'(bus_err), 32'd1);
      chk("timeout_req", 32'(dm_req), 32'd0);
      chk("timeout_ld_valid", 32'(ld_valid), 32'd0);
      mem_valid = 1'b0;
      #1 chk("timeout_stall", 32'(stall), 32'd0);
      chk("timeout_stall_cycles", 32'(stalls), 32'(TO + 1));
      dm_ack = 1'b1;  // late ack must be ignored
      dm_rdata = 32'h0BAD_0BAD;
      @(negedge clk);
      dm_ack = 1'b0;
      chk("late_ack_req", 32'(dm_req), 32'd0);
      chk("late_ack_buserr", 32'(bus_err), 32'd0);
      chk("late_ack_ld_valid", 32'(ld_valid), 32'd0);
      chk_ld_hold("late_ack");
      $display("op we=%0d size=%0d addr=%h -> timeout", we, size, addr);
    end
    mem_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    rst_n = 1'b0; mem_valid = 1'b0; mem_we = 1'b0; mem_size = 2'd0; mem_sign = 1'b0;
    mem_addr = '0; mem_wdata = '0; dm_ack = 1'b0; dm_rdata = '0;
    m_ld_data = '0; m_ld_byte = 1'b0; m_ld_half = 1'b0; m_ld_sign = 1'b0; m_ld_low = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(dm_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_be", 32'(dm_be), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_ld_valid", 32'(ld_valid), 32'd0);
    chk_ld_hold("rst");
    $display("reset state checked");
    rst_n = 1'b1;
    @(negedge clk);

    do_op(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3);
    do_op(1'b1, 2'd0, 1'b0, 32'h0000_0203, 32'h0000_00A5, 32'h0, 2);
    do_op(1'b0, 2'd1, 1'b1, 32'h0000_1002, 32'h0, 32'hFFFF_8001, 1);
    do_op(1'b0, 2'd2, 1'b0, 32'h0000_1001, 32'h0, 32'h0, 1);
    do_op(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 100);
    do_op(1'b1, 2'd2, 1'b0, 32'h0000_0044, 32'h1234_5678, 32'h0, 1);
    do_op(1'b0, 2'd0, 1'b1, 32'h0000_0301, 32'h0, 32'h5566_7788, TO);

    // Reset in the middle of an access.
    mem_valid = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h0000_0500;
    @(negedge clk);
    chk("pre_rst_req", 32'(dm_req), 32'd1);
    rst_n = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    chk("midrst_req", 32'(dm_req), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_ld_valid", 32'(ld_valid), 32'd0);
    m_ld_data = '0; m_ld_byte = 1'b0; m_ld_half = 1'b0; m_ld_sign = 1'b0; m_ld_low = 2'd0;
    chk_ld_hold("midrst");
    $display("reset mid-access checked");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) a = a & 32'hFFFF_FFFC;
      do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
            $urandom_range(1, TO + 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
